// File: rtl/node_skid_rx.sv
// Credit-reserved skid buffer on the receive side of a registered-ready link; optional bypass via NODE_SKID_RX_BYPASS_EN.
// Latency: 1 cycle from upstream accept to valid_down_out (0 cycles on bypass). Backpressure: ready_up_out drops once buffered plus in-flight beats fill DEPTH.
module node_skid_rx #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 4,
    parameter int READY_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_up_in,
    output logic             ready_up_out,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_down_out,
    input  logic             ready_down_in
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(DEPTH + READY_LAT + 1);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_next;
    logic [READY_LAT-1:0] hist;
    logic [READY_LAT-1:0] hist_next;
    logic [SW-1:0]        reserved_next;
    logic                 ready_next;
    logic                 up_fire;
    logic                 down_fire;
    logic                 bypass;
    logic                 push;
    logic                 pop;

    // hist[READY_LAT-1] is the ready value the upstream is acting on this cycle
    generate
        if (READY_LAT == 1) begin : g_hist1
            assign hist_next = ready_up_out;
        end else begin : g_histn
            assign hist_next = {hist[READY_LAT-2:0], ready_up_out};
        end
    endgenerate

    assign up_fire = valid_up_in & hist[READY_LAT-1];

`ifdef NODE_SKID_RX_BYPASS_EN
    assign bypass         = (count == '0) & up_fire & ready_down_in;
    assign valid_down_out = (count != '0) | bypass;
    assign data_out       = bypass ? data_in : mem[rd_ptr];
`else
    assign bypass         = 1'b0;
    assign valid_down_out = (count != '0);
    assign data_out       = mem[rd_ptr];
`endif

    assign down_fire = valid_down_out & ready_down_in;
    assign push      = up_fire & ~bypass;
    assign pop       = down_fire & ~bypass;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Every issued ready still travelling towards the upstream holds a slot, used or not
    always_comb begin
        reserved_next = '0;
        for (int i = 0; i < READY_LAT; i++) begin
            reserved_next = reserved_next + SW'(hist_next[i]);
        end
        ready_next = (SW'(count_next) + reserved_next) < SW'(DEPTH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_up_out <= 1'b0;
            hist         <= '0;
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            ready_up_out <= ready_next;
            hist         <= hist_next;
            count        <= count_next;
            if (push) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_node_skid_rx.sv
// Bench for node_skid_rx: directed vector table, then a queue-based reference model under random traffic.
module tb_node_skid_rx;

    localparam int WIDTH     = 32;
    localparam int DEPTH     = 4;
    localparam int READY_LAT = 1;

`ifdef NODE_SKID_RX_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] data_in;
    logic             valid_up_in;
    logic             ready_up_out;
    logic [WIDTH-1:0] data_out;
    logic             valid_down_out;
    logic             ready_down_in;

    node_skid_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .READY_LAT(READY_LAT)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .valid_up_in    (valid_up_in),
        .ready_up_out   (ready_up_out),
        .data_out       (data_out),
        .valid_down_out (valid_down_out),
        .ready_down_in  (ready_down_in)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        vin;
        logic [31:0] din;
        logic        rdy;
        logic        exp_rdy;
        logic        exp_vld;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t tbl[17];

    // Reference model: FIFO contents plus the ready grants still travelling to the upstream
    logic [31:0] mq[$];
    bit          grants[$];
    bit          m_ready;

    function automatic void model_reset();
        mq.delete();
        grants.delete();
        for (int i = 0; i < READY_LAT; i++) grants.push_back(1'b0);
        m_ready = 1'b0;
    endfunction

    function automatic bit m_bypass();
        return BYP && (mq.size() == 0) && valid_up_in && grants[0] && ready_down_in;
    endfunction

    function automatic bit m_valid();
        return (mq.size() != 0) || m_bypass();
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".ready"}, {31'd0, ready_up_out}, {31'd0, m_ready});
        chk({tag, ".valid"}, {31'd0, valid_down_out}, {31'd0, m_valid()});
        if (m_valid())
            chk({tag, ".data"}, data_out, (mq.size() != 0) ? mq[0] : data_in);
    endtask

    function automatic void model_edge();
        bit byp, up, dn;
        int inflight;
        byp = m_bypass();
        up  = valid_up_in && grants[0];
        dn  = m_valid() && ready_down_in;
        if (!byp) begin
            if (dn) void'(mq.pop_front());
            if (up) mq.push_back(data_in);
        end
        grants.push_back(m_ready);
        void'(grants.pop_front());
        inflight = 0;
        foreach (grants[i]) inflight += int'(grants[i]);
        m_ready = (mq.size() + inflight) < DEPTH;
    endfunction

    // Called at a negedge; returns at the following negedge
    task automatic step(input logic vin, input logic [31:0] din, input logic rdy, input string tag);
        valid_up_in   = vin;
        data_in       = din;
        ready_down_in = rdy;
        #1;
        check_outputs(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit flow;
        int guard;

        tbl[0]  = '{1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 32'h1,    1'b0, 1'b1, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 32'h2,    1'b0, 1'b1, 1'b1, 32'h1};
        tbl[4]  = '{1'b1, 32'h3,    1'b0, 1'b1, 1'b1, 32'h1};
        tbl[5]  = '{1'b1, 32'h4,    1'b0, 1'b0, 1'b1, 32'h1};
        tbl[6]  = '{1'b1, 32'h5,    1'b0, 1'b0, 1'b1, 32'h1};
        tbl[7]  = '{1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 32'h1};
        tbl[8]  = '{1'b1, 32'h6,    1'b1, 1'b1, 1'b1, 32'h2};
        tbl[9]  = '{1'b1, 32'h7,    1'b1, 1'b1, 1'b1, 32'h3};
        tbl[10] = '{1'b1, 32'h8,    1'b1, 1'b1, 1'b1, 32'h4};
        tbl[11] = '{1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 32'h7};
        tbl[12] = '{1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 32'h8};
        tbl[13] = '{1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 32'h0};
        tbl[14] = '{1'b1, 32'hA5,   1'b1, 1'b1, BYP,  32'hA5};
        tbl[15] = '{1'b0, 32'h0,    1'b1, 1'b1, !BYP, 32'hA5};
        tbl[16] = '{1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 32'h0};

        rst           = 1'b1;
        valid_up_in   = 1'b0;
        data_in       = '0;
        ready_down_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.ready", {31'd0, ready_up_out}, 32'd0);
        chk("reset.valid", {31'd0, valid_down_out}, 32'd0);
        chk("reset.data", data_out, 32'd0);

        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            valid_up_in   = tbl[i].vin;
            data_in       = tbl[i].din;
            ready_down_in = tbl[i].rdy;
            #1;
            chk($sformatf("vec%0d.ready", i), {31'd0, ready_up_out}, {31'd0, tbl[i].exp_rdy});
            chk($sformatf("vec%0d.valid", i), {31'd0, valid_down_out}, {31'd0, tbl[i].exp_vld});
            if (tbl[i].exp_vld)
                chk($sformatf("vec%0d.data", i), data_out, tbl[i].exp_dat);
            @(negedge clk);
        end

        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        for (int k = 1; k <= 16; k++)
            step(1'b1, 32'(k), 1'b1, "stream");
        repeat (4) step(1'b0, 32'h0, 1'b1, "drain");

        // Three beats buffered, then an asynchronous reset in mid-cycle
        guard = 0;
        while (mq.size() < 3 && guard < 20) begin
            step(1'b1, 32'h100 + 32'(guard), 1'b0, "fill");
            guard++;
        end
        chk("fill.beats", 32'(mq.size()), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.valid", {31'd0, valid_down_out}, 32'd0);
        chk("midrst.ready", {31'd0, ready_up_out}, 32'd0);
        chk("midrst.data", data_out, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        flow = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (c % 40 == 0) flow = ($urandom_range(0, 2) != 0);
            step(($urandom_range(0, 3) != 0), $urandom,
                 flow ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 5) == 0), "rand");
        end
        repeat (10) step(1'b0, 32'h0, 1'b1, "final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/node_skid_rx.md
# node_skid_rx

Receiving end of the registered-ready pipeline link. An upstream node that registers our ready for READY_LAT cycles before using it can keep sending for that long after we deassert ready. This block absorbs those in-flight beats in a small credit-reserved buffer so none are lost. It re-presents the data to the downstream stage on a standard same-cycle valid/ready handshake.

## Interface
- WIDTH, 32, data width in bits
- DEPTH, 4, buffer entries; power of two; must satisfy DEPTH >= READY_LAT+1
- READY_LAT, 1, cycles the upstream delays ready_up_out before qualifying its transfers; >= 1
- clk  in  1  single clock; all state on posedge
- rst  in  1  asynchronous, active-high reset
- data_in  in  WIDTH  upstream data
- valid_up_in  in  1  upstream valid; may be high while our delayed ready is 0
- ready_up_out  out  1  registered ready to upstream
- data_out  out  WIDTH  head-of-buffer data (or bypass data)
- valid_down_out  out  1  downstream valid
- ready_down_in  in  1  downstream ready, used same cycle

## Operation
- hist: shift register of the last READY_LAT values of ready_up_out. hist[READY_LAT-1] is the ready value the upstream sees this cycle.
- Upstream accept: up_fire = valid_up_in & hist[READY_LAT-1]. If valid_up_in=1 while hist[READY_LAT-1]=0, the beat is not a transfer and is ignored.
- Downstream transfer: down_fire = valid_down_out & ready_down_in.
- Buffer: circular, with wr_ptr and rd_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH. count is $clog2(DEPTH+1) bits, range 0..DEPTH.
  - up_fire pushes data_in.
  - down_fire pops.
  - Simultaneous push and pop leaves count unchanged.
- valid_down_out = (count != 0). data_out = mem[rd_ptr].
- Credit rule, evaluated each edge:
  - reserved_next = popcount of {ready_up_out, hist[READY_LAT-2:0]}, i.e. ready cycles issued whose arrival slot is still in the future.
  - ready_up_out <= (count_next + reserved_next) < DEPTH.
  - reserved_next counts every issued ready cycle, whether or not upstream uses it.
- Consequence: push never happens when count==DEPTH. No overflow path exists and no drop logic is required.
- Ordering is strictly FIFO. No beat is duplicated or lost.

## Timing
- Reset values (rst=1, asynchronous): ready_up_out=0, hist=0, count=0, both pointers=0, mem=0, valid_down_out=0, data_out=0.
- First ready_up_out=1 appears on the first clk edge after rst falls.
- Latency without bypass: a beat accepted at edge N is on data_out with valid_down_out=1 in the cycle after edge N.
- Throughput: 1 beat/cycle sustained when ready_down_in=1 and DEPTH >= READY_LAT+2.
- Downstream stall: ready_up_out falls within one cycle of reserved plus count reaching DEPTH. Beats still in flight land in reserved slots.
- Reset mid-operation: buffered beats are discarded, all outputs return to reset values immediately, and credits restart from zero.
- Full and empty at the same time is impossible by construction. A pop when count==0 cannot occur because valid_down_out=0.

## Configuration
- NODE_SKID_RX_BYPASS_EN defined: when count==0, up_fire=1 and ready_down_in=1, data_in is forwarded combinationally.
  - In that cycle, valid_down_out=1 and data_out=data_in.
  - No push occurs, giving zero-cycle latency.
  - In every other case the block behaves as without the macro.
- Not defined: valid_down_out depends only on count. Minimum latency is 1 cycle and the block has no combinational input-to-output paths.

## Test plan
- Reset, then rst=0 with ready_down_in=1, READY_LAT=1 -> ready_up_out=1 from the 1st edge. Stream 0x1..0x10 back-to-back -> all 16 beats out in order at 1/cycle, count <= 1.
- Hold ready_down_in=0, upstream sends every cycle its delayed ready=1 -> count stops at 4 (DEPTH=4). ready_up_out falls once count+reserved reaches 4. No beat lost. Release: beats drain in order.
- valid_up_in=1 with 0xDEAD while hist=0 -> no push, count unchanged, 0xDEAD never appears on data_out.
- Simultaneous push and pop at count=2 -> count stays 2. Pointer wrap past entry 3 -> data order preserved across wrap.
- Assert rst with 3 beats buffered -> valid_down_out=0, ready_up_out=0 immediately. After release, only new beats appear.
- With NODE_SKID_RX_BYPASS_EN, empty buffer, ready_down_in=1, beat 0xA5 -> data_out=0xA5 and valid_down_out=1 in the same cycle, count remains 0. Without the macro: visible one cycle later.
